// File: rtl/serial_compare_pkg.sv
// serial_compare_pkg
// Shared definitions for the bit-serial branch comparator:
//   - state_t : controller states (IDLE=0, SHIFT=1, DONE=2)
//   - br_t    : branch-condition encoding used downstream of eq/lt
//   - branch_taken() : maps a branch condition plus eq/lt to a taken flag.
//     The signed/unsigned split (BLT vs BLTU) is selected by the is_signed
//     input of the comparator, so LT/LTU share the same lt-based mapping.
package serial_compare_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } br_t;

  function automatic logic branch_taken(input br_t cond, input logic eq, input logic lt);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_EQ:          taken = eq;
      BR_NE:          taken = ~eq;
      BR_LT, BR_LTU:  taken = lt;
      BR_GE, BR_GEU:  taken = ~lt;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/serial_compare_if.sv
// serial_compare_if
// Request/result bundle for serial_compare.
//   start, is_signed, a, b : request side (driven by the requester)
//   busy, done, eq, lt     : status/result side (driven by the comparator)
// master: requester view; slave: comparator view.
interface serial_compare_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, eq, lt
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, eq, lt
  );

endinterface

// File: rtl/serial_compare_xnor.sv
// xnorGate
// Two-input XNOR equality cell.
//   a, b : input bits
//   y    : 1 when a == b
module xnorGate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/serial_compare.sv
// serial_compare
// Bit-serial two-word comparator producing eq/lt flags for branch
// resolution. Operands are latched into shift registers on an accepted
// start and consumed LSB first, one bit per clock, through an XNOR cell.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_compare_if slave (start/is_signed/a/b in,
//         busy/done/eq/lt out; all outputs registered)
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  serial_compare_if.slave    bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             signed_q, signed_d;
  logic             eq_acc_q, eq_acc_d;
  logic             lt_acc_q, lt_acc_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_eq;
  logic             last_bit;
  logic             lt_bit;

  xnorGate u_xnor (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .y (bit_eq)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // A higher bit that differs overrides everything below it; an equal bit
  // keeps the lower-order verdict. For a signed MSB the sign bit weighs
  // negative, so a=1/b=0 means a is the smaller operand.
  always_comb begin
    lt_bit = ~a_sh_q[0] & b_sh_q[0];
    if (last_bit && signed_q) begin
      lt_bit = a_sh_q[0] & ~b_sh_q[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    signed_d = signed_q;
    eq_acc_d = eq_acc_q;
    lt_acc_d = lt_acc_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          signed_d = bus.is_signed;
          cnt_d    = '0;
          eq_acc_d = 1'b1;
          lt_acc_d = 1'b0;
          eq_d     = 1'b0;
          lt_d     = 1'b0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        eq_acc_d = eq_acc_q & bit_eq;
        lt_acc_d = lt_bit | (bit_eq & lt_acc_q);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (last_bit) begin
          // Counter holds at the last index rather than wrapping.
          eq_d    = eq_acc_d;
          lt_d    = lt_acc_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      signed_q <= 1'b0;
      eq_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      signed_q <= signed_d;
      eq_acc_q <= eq_acc_d;
      lt_acc_q <= lt_acc_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;

endmodule
